// File: rtl/weight_feeder_pkg.sv
// Shared sizing constants and FSM encoding for the weight feeder.
// Imported by the tile buffer and the feeder top.
package weight_feeder_pkg;

    localparam int DATA_SIZE  = 8;
    localparam int MAC_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    localparam int NUM_MACS   = MAC_WIDTH * MAC_WIDTH;
    localparam int ROW_BITS   = MAC_WIDTH * DATA_SIZE;
    localparam int ALL_BITS   = NUM_MACS * DATA_SIZE;
    localparam int ROW_IDX_W  = $clog2(MAC_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_READY
    } wf_state_e;

endpackage

// File: rtl/weight_tile_buffer.sv
// 8x8 weight store: one full-row write port, every entry readable
// in parallel. Entry (r,c) appears at flat slice r*MAC_WIDTH+c.
module weight_tile_buffer
    import weight_feeder_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ROW_IDX_W-1:0] wr_row,
    input  logic [ROW_BITS-1:0]  wr_data,
    output logic [ALL_BITS-1:0]  rd_data
);

    logic [ROW_BITS-1:0] row_q [MAC_WIDTH];

    // Row storage, cleared by reset, written one row per valid beat
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int r = 0; r < MAC_WIDTH; r++) begin
                row_q[r] <= '0;
            end
        end else if (wr_en) begin
            row_q[wr_row] <= wr_data;
        end
    end

    // Flatten rows so slice k = row*MAC_WIDTH+col lines up with MAC k
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < MAC_WIDTH; r++) begin
            rd_data[r*ROW_BITS +: ROW_BITS] = row_q[r];
        end
    end

endmodule

// File: rtl/weight_feeder.sv
// Fetches an 8x8 weight tile row by row from memory, then serves
// per-MAC level-sensitive weight requests from the buffered tile.
module weight_feeder
    import weight_feeder_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [ROW_BITS-1:0]   mem_rd_data,
    input  logic                  mem_rd_valid,
    input  logic [NUM_MACS-1:0]   weights_request,
    output logic [ALL_BITS-1:0]   weights_data_out,
    output logic [NUM_MACS-1:0]   weights_ack,
    output logic                  tile_ready,
    output logic                  busy,
    output logic                  request_miss
);

    wf_state_e             state_q, state_d;
    logic [ROW_IDX_W-1:0]  row_q, row_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [NUM_MACS-1:0]   ack_q;
    logic [ALL_BITS-1:0]   data_q, data_d;
    logic                  miss_q;
    logic                  buf_wr;
    logic                  serving;
    logic [ALL_BITS-1:0]   buf_rd;

    weight_tile_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (buf_wr),
        .wr_row  (row_q),
        .wr_data (mem_rd_data),
        .rd_data (buf_rd)
    );

    // FSM, row counter and base address registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic; a single read in flight at any time
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        base_d  = base_q;
        unique case (state_q)
            ST_IDLE, ST_READY: begin
                if (load_start) begin
                    base_d  = load_base;
                    row_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mem_rd_valid) begin
                    if (row_q == ROW_IDX_W'(MAC_WIDTH - 1)) begin
                        state_d = ST_READY;
                    end else begin
                        row_d   = row_q + ROW_IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_rd_en  = (state_q == ST_FETCH);
    assign mem_addr   = base_q + ADDR_WIDTH'(row_q);
    assign buf_wr     = (state_q == ST_WAIT) && mem_rd_valid;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign tile_ready = (state_q == ST_READY);
    assign serving    = (state_q == ST_READY);

    // Update only requested slices; others keep their last value
    always_comb begin
        data_d = data_q;
        for (int k = 0; k < NUM_MACS; k++) begin
            if (serving && weights_request[k]) begin
                data_d[k*DATA_SIZE +: DATA_SIZE] =
                    buf_rd[k*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Registered delivery: ack and data one cycle after the request
    always_ff @(posedge clock) begin
        if (!reset) begin
            ack_q  <= '0;
            data_q <= '0;
            miss_q <= 1'b0;
        end else begin
            ack_q  <= serving ? weights_request : '0;
            data_q <= data_d;
            miss_q <= !serving && (|weights_request);
        end
    end

    assign weights_ack      = ack_q;
    assign weights_data_out = data_q;
    assign request_miss     = miss_q;

endmodule

// File: tb/tb_weight_feeder.sv
// Scoreboard bench for weight_feeder: memory responder model,
// expected reads and deliveries queued at stimulus time.
module tb_weight_feeder;
    import weight_feeder_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_base;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [ROW_BITS-1:0]   mem_rd_data;
    logic                  mem_rd_valid;
    logic [NUM_MACS-1:0]   weights_request;
    logic [ALL_BITS-1:0]   weights_data_out;
    logic [NUM_MACS-1:0]   weights_ack;
    logic                  tile_ready;
    logic                  busy;
    logic                  request_miss;

    always #5 clock = ~clock;

    weight_feeder dut (
        .clock            (clock),
        .reset            (reset),
        .load_start       (load_start),
        .load_base        (load_base),
        .mem_rd_en        (mem_rd_en),
        .mem_addr         (mem_addr),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_valid     (mem_rd_valid),
        .weights_request  (weights_request),
        .weights_data_out (weights_data_out),
        .weights_ack      (weights_ack),
        .tile_ready       (tile_ready),
        .busy             (busy),
        .request_miss     (request_miss)
    );

    typedef struct packed {
        logic [NUM_MACS-1:0] ack;
        logic [ALL_BITS-1:0] data;
        logic                miss;
    } exp_t;

    logic [ADDR_WIDTH-1:0] addr_q [$];
    exp_t                  sb [$];
    logic [7:0]            exp_buf [MAC_WIDTH][MAC_WIDTH];
    logic [ALL_BITS-1:0]   exp_data;
    logic                  exp_ready;
    int                    mode;
    logic [ADDR_WIDTH-1:0] tb_base;
    int                    cnt;
    logic [ADDR_WIDTH-1:0] pend_addr;
    int                    n_cmp;
    int                    n_err;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int m, input int r, input int c);
        if (m == 0) return 8'(r + 1);
        return 8'(r * 16 + c + 64);
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Memory model: answers each read two cycles after the strobe
    initial begin
        cnt = 0;
        forever begin
            @(posedge clock);
            #1;
            mem_rd_valid = 1'b0;
            mem_rd_data  = {16{$urandom}};
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    int r;
                    r = int'(16'(pend_addr - tb_base));
                    mem_rd_valid = 1'b1;
                    for (int c = 0; c < MAC_WIDTH; c++) begin
                        mem_rd_data[c*8 +: 8] = pat(mode, r, c);
                    end
                end
            end
            if (mem_rd_en === 1'b1) begin
                chk("rd_outstanding", 512'(cnt), 512'(0));
                if (addr_q.size() == 0) begin
                    chk("rd_unexpected", 512'(mem_addr), 512'(0));
                end else begin
                    chk("rd_addr", 512'(mem_addr), 512'(addr_q.pop_front()));
                end
                pend_addr = mem_addr;
                cnt = 2;
            end
        end
    end

    task automatic load_prep(input logic [15:0] base, input int m);
        tb_base = base;
        mode    = m;
        for (int r = 0; r < MAC_WIDTH; r++) begin
            addr_q.push_back(16'(base + 16'(r)));
        end
    endtask

    task automatic set_buf(input int m);
        for (int r = 0; r < MAC_WIDTH; r++) begin
            for (int c = 0; c < MAC_WIDTH; c++) begin
                exp_buf[r][c] = pat(m, r, c);
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && tile_ready !== 1'b1; i++) tick();
        chk("tile_ready", 512'(tile_ready), 512'(1));
        chk("reads_done", 512'(addr_q.size()), 512'(0));
        chk("busy_done", 512'(busy), 512'(0));
        exp_ready = 1'b1;
    endtask

    task automatic req_cycle(input logic [NUM_MACS-1:0] req);
        exp_t e;
        weights_request = req;
        e.ack  = exp_ready ? req : '0;
        if (exp_ready) begin
            for (int k = 0; k < NUM_MACS; k++) begin
                if (req[k]) exp_data[k*8 +: 8] = exp_buf[k/8][k%8];
            end
        end
        e.data = exp_data;
        e.miss = !exp_ready && (|req);
        sb.push_back(e);
        tick();
        weights_request = '0;
        e = sb.pop_front();
        chk("ack", 512'(weights_ack), 512'(e.ack));
        chk("data", weights_data_out, e.data);
        chk("miss", 512'(request_miss), 512'(e.miss));
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        reset           = 1'b0;
        load_start      = 1'b0;
        load_base       = '0;
        weights_request = '0;
        exp_data        = '0;
        exp_ready       = 1'b0;
        mode            = 0;
        tb_base         = '0;
        for (int r = 0; r < MAC_WIDTH; r++)
            for (int c = 0; c < MAC_WIDTH; c++) exp_buf[r][c] = 8'h00;
        tick();
        tick();
        chk("rst_ack", 512'(weights_ack), 512'(0));
        chk("rst_data", weights_data_out, 512'(0));
        chk("rst_rd_en", 512'(mem_rd_en), 512'(0));
        chk("rst_addr", 512'(mem_addr), 512'(0));
        chk("rst_ready", 512'(tile_ready), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_miss", 512'(request_miss), 512'(0));
        reset = 1'b1;
        tick();

        // request while idle
        req_cycle(64'h1 << 5);
        req_cycle('0);

        // first tile at 0x0010, rows of {8{r+1}}
        load_prep(16'h0010, 0);
        set_buf(0);
        load_start = 1'b1;
        load_base  = 16'h0010;
        tick();
        load_start = 1'b0;
        chk("busy_fetch", 512'(busy), 512'(1));
        tick();
        req_cycle(64'h1 << 7);
        load_start = 1'b1;
        load_base  = 16'h3333;
        tick();
        load_start = 1'b0;
        wait_ready();

        // single MAC 19 = row 2, col 3
        req_cycle(64'h1 << 19);
        chk("mac19_byte", 512'(weights_data_out[159:152]), 512'(8'h03));

        // all MACs held for three cycles
        for (int i = 0; i < 3; i++) req_cycle('1);

        // random request patterns
        for (int i = 0; i < 4; i++) req_cycle({$urandom, $urandom});

        // reload from READY with requests in the same cycle, wrapped base
        load_prep(16'hFFFC, 1);
        load_start = 1'b1;
        load_base  = 16'hFFFC;
        req_cycle('1);
        load_start = 1'b0;
        exp_ready  = 1'b0;
        set_buf(1);
        chk("reload_ready", 512'(tile_ready), 512'(0));
        chk("reload_busy", 512'(busy), 512'(1));
        req_cycle(64'hFF00);
        wait_ready();
        req_cycle('1);
        req_cycle({$urandom, $urandom});

        // reset mid-load while waiting on row 4, then a late valid
        load_prep(16'h0100, 0);
        set_buf(0);
        load_start = 1'b1;
        load_base  = 16'h0100;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 100 && addr_q.size() != 3; i++) tick();
        chk("reach_row4", 512'(addr_q.size()), 512'(3));
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        addr_q.delete();
        exp_data  = '0;
        exp_ready = 1'b0;
        chk("mid_busy", 512'(busy), 512'(0));
        chk("mid_ready", 512'(tile_ready), 512'(0));
        chk("mid_rd_en", 512'(mem_rd_en), 512'(0));
        chk("mid_addr", 512'(mem_addr), 512'(0));
        chk("mid_ack", 512'(weights_ack), 512'(0));
        chk("mid_data", weights_data_out, 512'(0));
        chk("mid_miss", 512'(request_miss), 512'(0));
        for (int i = 0; i < 4; i++) tick();
        chk("late_busy", 512'(busy), 512'(0));
        chk("late_ready", 512'(tile_ready), 512'(0));
        req_cycle('1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
